// File: rtl/vcb_mod_udl_if.sv
// Control/data bundle for the modulo up/down counter: count/load controls
// toward the counter, state and cascade flags back from it.
interface vcb_mod_udl_if #(
  parameter int WIDTH = 8
);
  logic             ce;
  logic             up;
  logic             L;
  logic [WIDTH-1:0] D;
  logic             clr_ovf;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             CEO;
  logic             OVF;

  modport master (
    output ce, up, L, D, clr_ovf,
    input  Q, TC, CEO, OVF
  );

  modport slave (
    input  ce, up, L, D, clr_ovf,
    output Q, TC, CEO, OVF
  );
endinterface

// File: rtl/vcb_mod_udl.sv
// WIDTH-bit modulo-MODULUS up/down counter with saturating parallel load,
// combinational terminal-count/cascade outputs and a sticky wrap flag.
module vcb_mod_udl #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic         clk,
  input  logic         R,
  vcb_mod_udl_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero, tc, wrap;

  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);
  assign tc      = bus.up ? at_max : at_zero;
  // A wrap is a count step taken at the terminal value; load and reset pre-empt it.
  assign wrap    = bus.ce & tc & ~bus.L & ~R;

  always_comb begin
    q_d = q_q;
    if (bus.L) begin
      q_d = (bus.D > MAX_VAL) ? MAX_VAL : bus.D;
    end else if (bus.ce) begin
      if (bus.up) begin
        q_d = at_max ? '0 : q_q + 1'b1;
      end else begin
        q_d = at_zero ? MAX_VAL : q_q - 1'b1;
      end
    end
    ovf_d = wrap | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.TC  = tc;
  assign bus.CEO = wrap;
  assign bus.OVF = ovf_q;
endmodule
